demux1_4_buf: RTL and testbench



---
 rtl/demux1_4_buf_pkg.sv | 12 +
 rtl/demux1_4_buf_if.sv | 22 ++
 rtl/demux1_4_buf_chan_fifo.sv | 47 ++++
 rtl/demux1_4_buf.sv | 62 ++++++
 tb/tb_demux1_4_buf.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/demux1_4_buf_pkg.sv
// rtl/demux1_4_buf_pkg.sv - shared constants and channel index type for the 1:4 buffered demux
package demux1_4_buf_pkg;
   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef logic [SEL_W-1:0] chan_idx_t;

   // Round-robin successor; wraps 3 -> 0 through the natural 2-bit overflow.
   function automatic chan_idx_t next_chan(input chan_idx_t c);
      return c + chan_idx_t'(1);
   endfunction
endpackage

// File: rtl/demux1_4_buf_if.sv
// rtl/demux1_4_buf_if.sv - input beat stream and four output channels of the 1:4 buffered demux
interface demux1_4_buf_if #(parameter int WIDTH = 2);
   import demux1_4_buf_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        in_data;
   chan_idx_t               in_sel;
   logic [NUM_CH*WIDTH-1:0] out_data;
   logic [NUM_CH-1:0]       out_valid;
   logic [NUM_CH-1:0]       out_ready;

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/demux1_4_buf_chan_fifo.sv
// rtl/demux1_4_buf_chan_fifo.sv - first-word-fall-through per-channel FIFO
// Pointers carry one extra wrap bit so full and empty are distinguishable at equal low bits.
module demux_chan_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end
endmodule

// File: rtl/demux1_4_buf.sv
// rtl/demux1_4_buf.sv - buffered 1:4 demux: target select, sequencer, push decode, four FIFOs
// in_ready looks only at FIFO fullness so no combinational path runs from out_ready to in_ready.
module demux1_4_buf
   import demux1_4_buf_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               auto_mode,
   output chan_idx_t          seq_sel,
   demux1_4_buf_if.slave      bus
);
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop;
   logic [WIDTH-1:0]  head [NUM_CH];
   chan_idx_t         tgt;
   logic              accept;

   assign tgt          = auto_mode ? seq_sel : bus.in_sel;
   assign bus.in_ready = !full[tgt];
   assign accept       = bus.in_valid && bus.in_ready;
   assign bus.out_valid = ~empty;

   // Sequencer moves only on an accepted auto-mode beat, so stalls keep strict order.
   always_ff @(posedge clk) begin
      if (rst) begin
         seq_sel <= '0;
      end else if (accept && auto_mode) begin
         seq_sel <= next_chan(seq_sel);
      end
   end

   always_comb begin
      bus.out_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         bus.out_data[i*WIDTH +: WIDTH] = head[i];
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign push[i] = accept && (tgt == chan_idx_t'(i));
      assign pop[i]  = bus.out_ready[i] && !empty[i];

      demux_chan_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[i]),
         .pop   (pop[i]),
         .din   (bus.in_data),
         .full  (full[i]),
         .empty (empty[i]),
         .head  (head[i])
      );
   end
endmodule

// File: tb/tb_demux1_4_buf.sv
// tb/tb_demux1_4_buf.sv - scoreboard bench for the buffered 1:4 demux
module tb_demux1_4_buf;
   import demux1_4_buf_pkg::*;

   localparam int WIDTH = 2;
   localparam int DEPTH = 2;

   logic      clk = 1'b0;
   logic      rst;
   logic      auto_mode;
   chan_idx_t seq_sel;

   demux1_4_buf_if #(.WIDTH(WIDTH)) bus ();

   demux1_4_buf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .auto_mode (auto_mode),
      .seq_sel   (seq_sel),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int               tests = 0;
   int               fails = 0;
   logic [WIDTH-1:0] exp_q [NUM_CH][$];
   chan_idx_t        model_seq;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: every valid head must match the oldest expected beat for that lane.
   always @(negedge clk) begin
      logic [WIDTH-1:0] lane;
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            lane = bus.out_data[i*WIDTH +: WIDTH];
            if (bus.out_valid[i]) begin
               if (exp_q[i].size() == 0) begin
                  check($sformatf("unexpected_valid_ch%0d", i), int'(bus.out_valid[i]), 0);
               end else begin
                  check($sformatf("data_ch%0d", i), int'(lane), int'(exp_q[i][0]));
                  if (bus.out_ready[i]) void'(exp_q[i].pop_front());
               end
            end else begin
               check($sformatf("idle_zero_ch%0d", i), int'(lane), 0);
            end
         end
      end
   end

   // Present a beat and hold it until accepted; waits = cycles spent stalled.
   task automatic send(input logic [WIDTH-1:0] d, input chan_idx_t sel, output int waits);
      chan_idx_t t;
      bit        done;
      done  = 1'b0;
      waits = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_sel   = sel;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         check("seq_sel_track", int'(seq_sel), int'(model_seq));
         if (bus.in_ready) begin
            t = auto_mode ? model_seq : sel;
            exp_q[t].push_back(d);
            if (auto_mode) model_seq = model_seq + chan_idx_t'(1);
            done = 1'b1;
         end else begin
            waits++;
         end
         @(posedge clk); #1;
      end
      if (!done) check("send_timeout", int'(bus.in_ready), 1);
   endtask

   task automatic drain();
      bus.out_ready = '1;
      repeat (DEPTH + 3) @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
         check($sformatf("drained_ch%0d", i), exp_q[i].size(), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] man_d [NUM_CH];
      int               w;
      man_d = '{2'd3, 2'd0, 2'd1, 2'd2};

      rst           = 1'b1;
      auto_mode     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_sel    = '0;
      bus.out_ready = '0;
      model_seq     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_data", int'(bus.out_data), 0);
      check("rst_seq_sel", int'(seq_sel), 0);
      check("rst_in_ready", int'(bus.in_ready), 1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Manual routing, lanes d0..d3 = 3,0,1,2, one-cycle latency.
      bus.out_ready = '1;
      for (int i = 0; i < NUM_CH; i++) begin
         send(man_d[i], chan_idx_t'(i), w);
         check("man_wait", w, 0);
         bus.in_valid = 1'b0;
         @(negedge clk);
         check("man_valid_pulse", int'(bus.out_valid), 1 << i);
         check("man_in_ready", int'(bus.in_ready), 1);
         @(posedge clk); #1;
      end
      drain();

      // Auto mode round robin.
      auto_mode = 1'b1;
      for (int i = 0; i < 8; i++) send(WIDTH'(i % 4), 2'd0, w);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("auto_seq_wrap", int'(seq_sel), 0);
      @(posedge clk); #1;
      drain();

      // Backpressure on channel 2.
      auto_mode     = 1'b0;
      bus.out_ready = 4'b1011;
      send(2'd1, 2'd2, w);
      send(2'd2, 2'd2, w);
      bus.in_data = 2'd3;
      @(negedge clk);
      check("bp_full_ready", int'(bus.in_ready), 0);
      @(posedge clk); #1;
      bus.out_ready = 4'b1111;
      @(negedge clk);
      check("bp_pop_cycle_ready", int'(bus.in_ready), 0);
      @(posedge clk); #1;
      bus.out_ready = 4'b1011;
      send(2'd3, 2'd2, w);
      check("bp_resume_wait", w, 0);
      bus.in_valid = 1'b0;
      drain();

      // Full channel 1 with same-cycle pop: push refused, then accepted.
      bus.out_ready = 4'b1101;
      send(2'd1, 2'd1, w);
      send(2'd2, 2'd1, w);
      bus.in_data   = 2'd3;
      bus.out_ready = 4'b1111;
      @(negedge clk);
      check("fp_push_refused", int'(bus.in_ready), 0);
      @(posedge clk); #1;
      bus.out_ready = 4'b1101;
      send(2'd3, 2'd1, w);
      check("fp_accept_wait", w, 0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("fp_occupancy_two", int'(bus.in_ready), 0);
      @(posedge clk); #1;
      drain();

      // Auto stall with channel 1 full at seq_sel = 1.
      auto_mode     = 1'b1;
      bus.out_ready = 4'b1101;
      for (int i = 0; i < 9; i++) send(WIDTH'(i % 4), 2'd0, w);
      bus.in_data = 2'd3;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_in_ready", int'(bus.in_ready), 0);
         check("stall_seq_hold", int'(seq_sel), 1);
         @(posedge clk); #1;
      end
      bus.out_ready = 4'b1111;
      send(2'd3, 2'd0, w);
      check("stall_release_wait", w, 1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("stall_seq_after", int'(seq_sel), 2);
      @(posedge clk); #1;
      drain();

      // Reset mid-stream with a beat offered during reset.
      auto_mode     = 1'b0;
      bus.out_ready = 4'b0000;
      send(2'd1, 2'd0, w);
      send(2'd2, 2'd1, w);
      send(2'd3, 2'd2, w);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", int'(bus.out_valid), 4'b0111);
      check("seq_hold_manual", int'(seq_sel), 2);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = 2'd2;
      bus.in_sel   = 2'd3;
      rst          = 1'b1;
      for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
      model_seq = '0;
      @(posedge clk); #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", int'(bus.out_valid), 0);
      check("mid_rst_out_data", int'(bus.out_data), 0);
      check("mid_rst_seq_sel", int'(seq_sel), 0);
      check("mid_rst_in_ready", int'(bus.in_ready), 1);
      @(posedge clk); #1;
      drain();

      send(2'd1, 2'd3, w);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_ch3", int'(bus.out_valid), 4'b1000);
      @(posedge clk); #1;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
